// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: 24 h timekeeper with N_ALARM programmable alarm slots,
// snooze and ring time-out.
//
// Ports:
//   iCLK, iRSTn                 clock, asynchronous active-low reset
//   iEN                         timekeeping enable (prescaler, time and timers hold when low)
//   iSET, iSET_HH/MM/SS         one-cycle time load; out-of-range values are ignored
//   iAL_WE, iAL_SEL, iAL_HH/MM, iAL_ARM   alarm slot write
//   iSNOOZE, iDISMISS           one-cycle user pulses
//   iMODE12                     12 h display select for oHH
//   oHH/oMM/oSS, oPM            current time (oHH follows display mode)
//   oTICK                       one-cycle pulse per elapsed second
//   oRING, oSNZ, oRING_ID       alarm sounding, snoozing, active slot index
//   oARMED                      armed bit of every slot
module alarm_clock_multi #(
  parameter int CLK_HZ     = 50000000,
  parameter int N_ALARM    = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  localparam int AW        = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               iCLK,
  input  logic               iRSTn,
  input  logic               iEN,
  input  logic               iSET,
  input  logic [4:0]         iSET_HH,
  input  logic [5:0]         iSET_MM,
  input  logic [5:0]         iSET_SS,
  input  logic               iAL_WE,
  input  logic [AW-1:0]      iAL_SEL,
  input  logic [4:0]         iAL_HH,
  input  logic [5:0]         iAL_MM,
  input  logic               iAL_ARM,
  input  logic               iSNOOZE,
  input  logic               iDISMISS,
  input  logic               iMODE12,
  output logic [4:0]         oHH,
  output logic [5:0]         oMM,
  output logic [5:0]         oSS,
  output logic               oPM,
  output logic               oTICK,
  output logic               oRING,
  output logic [AW-1:0]      oRING_ID,
  output logic               oSNZ,
  output logic [N_ALARM-1:0] oARMED
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_HZ - 1);
  localparam logic [11:0]   RING_LOAD = 12'(RING_SEC);
  localparam logic [11:0]   SNZ_LOAD  = 12'(SNOOZE_MIN * 60);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  logic [PW-1:0] pre;
  logic [4:0]    hh;
  logic [5:0]    mm, ss;
  logic [4:0]    hh_inc, hh_nxt, disp_hh;
  logic [5:0]    mm_inc, ss_inc, mm_nxt, ss_nxt;
  logic          set_ok, wr_ok, tick;
  logic [4:0]    al_hh [N_ALARM];
  logic [5:0]    al_mm [N_ALARM];
  logic          hit, match;
  logic [AW-1:0] hit_id, ring_id, id_n;
  logic [11:0]   tmr, tmr_n;
  state_t        state, state_n;

  assign oMM      = mm;
  assign oSS      = ss;
  assign oRING_ID = ring_id;

  assign set_ok = iSET && (iSET_HH <= 5'd23) && (iSET_MM <= 6'd59) && (iSET_SS <= 6'd59);
  assign wr_ok  = iAL_WE && (32'(iAL_SEL) < N_ALARM) && (iAL_HH <= 5'd23) && (iAL_MM <= 6'd59);
  // A valid load pre-empts the prescaler wrap, so no second is counted that cycle.
  assign tick   = iEN && (pre == PRE_LAST) && !set_ok;

  always_comb begin
    ss_inc = ss + 6'd1;
    mm_inc = mm;
    hh_inc = hh;
    if (ss == 6'd59) begin
      ss_inc = '0;
      mm_inc = mm + 6'd1;
      if (mm == 6'd59) begin
        mm_inc = '0;
        hh_inc = (hh == 5'd23) ? '0 : hh + 5'd1;
      end
    end

    hh_nxt = hh;
    mm_nxt = mm;
    ss_nxt = ss;
    if (set_ok) begin
      hh_nxt = iSET_HH;
      mm_nxt = iSET_MM;
      ss_nxt = iSET_SS;
    end else if (tick) begin
      hh_nxt = hh_inc;
      mm_nxt = mm_inc;
      ss_nxt = ss_inc;
    end

    if (!iMODE12)             disp_hh = hh_nxt;
    else if (hh_nxt == 5'd0)  disp_hh = 5'd12;
    else if (hh_nxt > 5'd12)  disp_hh = hh_nxt - 5'd12;
    else                      disp_hh = hh_nxt;
  end

  // Compare against the incremented time so the match lands on the tick
  // that produces HH:MM:00; ascending scan keeps the lowest armed index.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int unsigned i = 0; i < N_ALARM; i++) begin
      if (!hit && oARMED[i] && (al_hh[i] == hh_inc) && (al_mm[i] == mm_inc)) begin
        hit    = 1'b1;
        hit_id = AW'(i);
      end
    end
    match = tick && (ss == 6'd59) && hit;
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      pre    <= '0;
      hh     <= '0;
      mm     <= '0;
      ss     <= '0;
      oHH    <= '0;
      oPM    <= 1'b0;
      oTICK  <= 1'b0;
      oARMED <= '0;
      for (int unsigned i = 0; i < N_ALARM; i++) begin
        al_hh[i] <= '0;
        al_mm[i] <= '0;
      end
    end else begin
      if (set_ok)    pre <= '0;
      else if (iEN)  pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      hh    <= hh_nxt;
      mm    <= mm_nxt;
      ss    <= ss_nxt;
      oHH   <= disp_hh;
      oPM   <= (hh_nxt >= 5'd12);
      oTICK <= tick;
      if (wr_ok) begin
        al_hh[iAL_SEL]  <= iAL_HH;
        al_mm[iAL_SEL]  <= iAL_MM;
        oARMED[iAL_SEL] <= iAL_ARM;
      end
    end
  end

  // tmr counts remaining ticks in RING (time-out) and in SNOOZE (wake-up).
  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    id_n    = ring_id;
    if (set_ok) begin
      state_n = IDLE;
    end else if (wr_ok && (state != IDLE) && (iAL_SEL == ring_id)) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            state_n = RING;
            id_n    = hit_id;
            tmr_n   = RING_LOAD;
          end
        end
        RING: begin
          if (iDISMISS) begin
            state_n = IDLE;
          end else if (iSNOOZE) begin
            state_n = SNOOZE;
            tmr_n   = SNZ_LOAD;
          end else if (tick) begin
            if (tmr == 12'd1) state_n = IDLE;
            else              tmr_n   = tmr - 12'd1;
          end
        end
        SNOOZE: begin
          if (iDISMISS) begin
            state_n = IDLE;
          end else if (tick) begin
            if (tmr == 12'd1) begin
              state_n = RING;
              tmr_n   = RING_LOAD;
            end else begin
              tmr_n = tmr - 12'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state   <= IDLE;
      tmr     <= '0;
      ring_id <= '0;
      oRING   <= 1'b0;
      oSNZ    <= 1'b0;
    end else begin
      state   <= state_n;
      tmr     <= tmr_n;
      ring_id <= id_n;
      oRING   <= (state_n == RING);
      oSNZ    <= (state_n == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Self-checking bench for alarm_clock_multi (CLK_HZ=4, N_ALARM=4,
// SNOOZE_MIN=1, RING_SEC=3). A seconds-of-day reference model predicts the
// full output vector after every clock edge; a monitor compares it.
module tb_alarm_clock_multi;

  localparam int CLK_HZ     = 4;
  localparam int N_ALARM    = 4;
  localparam int SNOOZE_MIN = 1;
  localparam int RING_SEC   = 3;
  localparam int AW         = 2;
  localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2;

  logic          iCLK = 1'b0, iRSTn = 1'b0, iEN = 1'b0, iSET = 1'b0;
  logic [4:0]    iSET_HH = '0;
  logic [5:0]    iSET_MM = '0, iSET_SS = '0;
  logic          iAL_WE = 1'b0;
  logic [AW-1:0] iAL_SEL = '0;
  logic [4:0]    iAL_HH = '0;
  logic [5:0]    iAL_MM = '0;
  logic          iAL_ARM = 1'b0, iSNOOZE = 1'b0, iDISMISS = 1'b0, iMODE12 = 1'b0;
  logic [4:0]    oHH;
  logic [5:0]    oMM, oSS;
  logic          oPM, oTICK, oRING, oSNZ;
  logic [AW-1:0] oRING_ID;
  logic [N_ALARM-1:0] oARMED;

  typedef logic [26:0] obs_t;
  obs_t exp_q[$];
  int n_cmp = 0, n_bad = 0, mon_cyc = 0;

  // reference model state
  int m_secs, m_pre, m_st, m_rem, m_rid;
  int m_h[N_ALARM], m_m[N_ALARM];
  bit m_a[N_ALARM];
  bit m_tick;

  alarm_clock_multi #(
    .CLK_HZ(CLK_HZ), .N_ALARM(N_ALARM), .SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)
  ) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iEN(iEN), .iSET(iSET),
    .iSET_HH(iSET_HH), .iSET_MM(iSET_MM), .iSET_SS(iSET_SS),
    .iAL_WE(iAL_WE), .iAL_SEL(iAL_SEL), .iAL_HH(iAL_HH), .iAL_MM(iAL_MM),
    .iAL_ARM(iAL_ARM), .iSNOOZE(iSNOOZE), .iDISMISS(iDISMISS), .iMODE12(iMODE12),
    .oHH(oHH), .oMM(oMM), .oSS(oSS), .oPM(oPM), .oTICK(oTICK), .oRING(oRING),
    .oRING_ID(oRING_ID), .oSNZ(oSNZ), .oARMED(oARMED)
  );

  always #5 iCLK = ~iCLK;

  function automatic obs_t dut_obs();
    return {oHH, oMM, oSS, oPM, oTICK, oRING, oRING_ID, oSNZ, oARMED};
  endfunction

  always @(posedge iCLK) begin
    obs_t e;
    obs_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_obs();
      n_cmp++;
      if (a !== e)
        begin
          n_bad++;
          $display("FAIL cycle%0d {HH,MM,SS,PM,TICK,RING,ID,SNZ,ARMED}: got %h required %h",
                   mon_cyc, a, e);
        end
      mon_cyc++;
    end
  end

  function automatic void model_reset();
    m_secs = 0; m_pre = 0; m_st = M_IDLE; m_rem = 0; m_rid = 0; m_tick = 0;
    for (int i = 0; i < N_ALARM; i++) begin
      m_h[i] = 0; m_m[i] = 0; m_a[i] = 0;
    end
  endfunction

  function automatic obs_t model_obs();
    int h, dh;
    logic [N_ALARM-1:0] arm;
    h  = m_secs / 3600;
    dh = !iMODE12 ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
    for (int i = 0; i < N_ALARM; i++) arm[i] = m_a[i];
    return {5'(dh), 6'((m_secs / 60) % 60), 6'(m_secs % 60), h >= 12, m_tick,
            m_st == M_RING, 2'(m_rid), m_st == M_SNZ, arm};
  endfunction

  function automatic void model_step();
    bit set_ok, wr_ok, tk;
    int win;
    if (!iRSTn) begin
      model_reset();
      return;
    end
    set_ok = iSET && iSET_HH <= 23 && iSET_MM <= 59 && iSET_SS <= 59;
    wr_ok  = iAL_WE && int'(iAL_SEL) < N_ALARM && iAL_HH <= 23 && iAL_MM <= 59;
    tk     = iEN && m_pre == CLK_HZ - 1 && !set_ok;
    win    = -1;
    if (set_ok) begin
      m_secs = int'(iSET_HH) * 3600 + int'(iSET_MM) * 60 + int'(iSET_SS);
      m_pre  = 0;
    end else if (iEN) begin
      m_pre = (m_pre + 1) % CLK_HZ;
      if (tk) m_secs = (m_secs + 1) % 86400;
    end
    if (tk && m_secs % 60 == 0)
      for (int i = N_ALARM - 1; i >= 0; i--)
        if (m_a[i] && m_h[i] * 3600 + m_m[i] * 60 == m_secs) win = i;

    if (set_ok) m_st = M_IDLE;
    else if (wr_ok && m_st != M_IDLE && int'(iAL_SEL) == m_rid) m_st = M_IDLE;
    else if (m_st == M_IDLE) begin
      if (win >= 0) begin
        m_st = M_RING; m_rid = win; m_rem = RING_SEC;
      end
    end else if (iDISMISS) m_st = M_IDLE;
    else if (m_st == M_RING && iSNOOZE) begin
      m_st = M_SNZ; m_rem = SNOOZE_MIN * 60;
    end else if (tk) begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_st == M_RING) m_st = M_IDLE;
        else begin
          m_st = M_RING; m_rem = RING_SEC;
        end
      end
    end

    if (wr_ok) begin
      m_h[iAL_SEL] = iAL_HH; m_m[iAL_SEL] = iAL_MM; m_a[iAL_SEL] = iAL_ARM;
    end
    m_tick = tk;
  endfunction

  // Called just after a negedge with inputs already driven for the next edge.
  task automatic step();
    model_step();
    exp_q.push_back(model_obs());
    @(negedge iCLK);
    iSET = 1'b0; iAL_WE = 1'b0; iSNOOZE = 1'b0; iDISMISS = 1'b0;
  endtask

  task automatic do_set(input int h, input int m, input int s);
    iSET = 1'b1; iSET_HH = 5'(h); iSET_MM = 6'(m); iSET_SS = 6'(s);
    step();
  endtask

  task automatic do_wr(input int sel, input int h, input int m, input bit arm);
    iAL_WE = 1'b1; iAL_SEL = AW'(sel); iAL_HH = 5'(h); iAL_MM = 6'(m); iAL_ARM = arm;
    step();
  endtask

  task automatic ring_up();
    do_set(6, 59, 59);
    repeat (CLK_HZ + 1) step();
  endtask

  initial begin
    int t, j;
    model_reset();
    @(negedge iCLK);
    repeat (3) step();
    iRSTn = 1'b1;
    iEN   = 1'b1;

    // midnight rollover, disarmed 00:00 slots stay silent
    do_set(23, 59, 58);
    repeat (10) step();

    // 12 h display
    iMODE12 = 1'b1;
    do_set(0, 30, 0);  step();
    do_set(12, 30, 0); step();
    do_set(13, 30, 0); step();
    iMODE12 = 1'b0;

    // two slots at 07:00, lowest index wins, then ring time-out
    do_wr(2, 7, 0, 1'b1);
    do_wr(1, 7, 0, 1'b1);
    ring_up();
    repeat (RING_SEC * CLK_HZ + 2) step();

    // snooze, re-ring after SNOOZE_MIN minutes, dismiss
    ring_up();
    iSNOOZE = 1'b1; step();
    repeat (SNOOZE_MIN * 60 * CLK_HZ + 4) step();
    iDISMISS = 1'b1; step();
    repeat (2) step();

    // snooze and dismiss together
    ring_up();
    iSNOOZE = 1'b1; iDISMISS = 1'b1; step();
    repeat (2) step();

    // valid set colliding with a tick
    for (int k = 0; k < 2 * CLK_HZ && m_pre != CLK_HZ - 1; k++) step();
    do_set(10, 20, 30);
    repeat (3) step();

    // invalid sets ignored
    do_set(5, 5, 60);
    do_set(24, 0, 0);
    do_wr(3, 24, 0, 1'b1);
    do_wr(3, 1, 60, 1'b1);
    step();

    // timers freeze with iEN=0, user pulses still act; write to ringing slot
    ring_up();
    iEN = 1'b0;
    repeat (20) step();
    iSNOOZE = 1'b1; step();
    repeat (10) step();
    iEN = 1'b1;
    repeat (8) step();
    do_wr(1, 8, 0, 1'b1);
    repeat (3) step();

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      iEN = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) iMODE12 = ~iMODE12;
      t = $urandom_range(0, 199);
      if (t < 3) begin
        j = $urandom_range(0, N_ALARM - 1);
        t = (m_h[j] * 3600 + m_m[j] * 60 - 1 - $urandom_range(0, 2) + 86400) % 86400;
        iSET = 1'b1; iSET_HH = 5'(t / 3600); iSET_MM = 6'((t / 60) % 60); iSET_SS = 6'(t % 60);
      end else if (t < 5) begin
        iSET = 1'b1; iSET_HH = 5'($urandom_range(0, 25));
        iSET_MM = 6'($urandom_range(0, 61)); iSET_SS = 6'($urandom_range(0, 61));
      end else if (t < 9) begin
        iAL_WE = 1'b1; iAL_SEL = AW'($urandom_range(0, N_ALARM - 1));
        iAL_HH = 5'($urandom_range(0, 25)); iAL_MM = 6'($urandom_range(0, 61));
        iAL_ARM = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 39) == 0) iSNOOZE = 1'b1;
      if ($urandom_range(0, 59) == 0) iDISMISS = 1'b1;
      step();
    end

    // asynchronous reset between edges while ringing
    iEN = 1'b1;
    do_wr(1, 7, 0, 1'b1);
    ring_up();
    #2;
    iRSTn = 1'b0;
    #1;
    n_cmp++;
    if ({oRING, oSNZ, oTICK, oHH, oMM, oSS, oARMED} !== '0) begin
      n_bad++;
      $display("FAIL async_reset {RING,SNZ,TICK,HH,MM,SS,ARMED}: got %h required 0",
               {oRING, oSNZ, oTICK, oHH, oMM, oSS, oARMED});
    end
    model_reset();
    @(negedge iCLK);
    step();
    iRSTn = 1'b1;
    repeat (2 * CLK_HZ + 2) step();

    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
